// File: rtl/mcp_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mcp_mem_port_if
// Brief    : Memory-side req/ack bus between mcp_mem_port and external memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mcp_mem_port_if #(
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o32;
  logic [DATA_W-1:0] mem_wdata_o32;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i32;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o32,
    output mem_wdata_o32,
    input  mem_ack_i,
    input  mem_rdata_i32
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o32,
    input  mem_wdata_o32,
    output mem_ack_i,
    output mem_rdata_i32
  );
endinterface
`default_nettype wire

// File: rtl/mcp_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : mcp_mem_port
// Brief    : Unified I/D memory port for the multicycle MIPS core; owns IR/MDR.
// Revision : 1.0 - initial release
// ============================================================================
module mcp_mem_port #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] pc_i32,
  input  logic [DATA_W-1:0] alu_out_i32,
  input  logic [DATA_W-1:0] wdata_i32,
  input  logic              instr_or_data_i,
  input  logic              instr_we_i,
  input  logic              enable_wmem_i,
  input  logic              mem_rd_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] instr_o32,
  output logic [DATA_W-1:0] data_o32,
  output logic              bus_err_o,
  mcp_mem_port_if.master    mem
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  state_t            r_state;
  state_t            w_state_nxt;
  op_t               r_op;
  op_t               w_op_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic              r_bus_err;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;

  logic w_any_req;
  logic w_illegal;
  logic w_accept;
  logic w_ack_take;
  logic w_timeout;
  logic w_stall;

  assign w_any_req = instr_we_i | enable_wmem_i | mem_rd_i;
  // A fetch and a store in the same cycle is a controller bug: run the fetch, flag it.
  assign w_illegal = instr_we_i & enable_wmem_i;

  always_comb begin
    w_op_sel = OP_STORE;
    if (instr_we_i) begin
      w_op_sel = OP_FETCH;
    end else if (mem_rd_i) begin
      w_op_sel = OP_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_accept    = 1'b0;
    w_ack_take  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_stall     = 1'b1;
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (mem.mem_ack_i) begin
          w_ack_take  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_op      <= OP_FETCH;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_bus_err <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ir      <= '0;
      r_mdr     <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= instr_or_data_i ? alu_out_i32 : pc_i32;
        r_wdata <= wdata_i32;
        r_req   <= 1'b1;
        r_we    <= (w_op_sel == OP_STORE);
        r_op    <= w_op_sel;
        if (w_illegal) begin
          r_bus_err <= 1'b1;
        end
      end
      if (w_ack_take) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
        if (r_op == OP_FETCH) begin
          r_ir <= mem.mem_rdata_i32;
        end
        if (r_op == OP_LOAD) begin
          r_mdr <= mem.mem_rdata_i32;
        end
      end
      if (w_timeout) begin
        r_req     <= 1'b0;
        r_we      <= 1'b0;
        r_bus_err <= 1'b1;
      end
      // Counter runs only while waiting; it is cleared once the access leaves REQ.
      if (r_state == ST_REQ) begin
        if (!w_ack_take && !w_timeout) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign stall_o           = w_stall;
  assign instr_o32         = r_ir;
  assign data_o32          = r_mdr;
  assign bus_err_o         = r_bus_err;
  assign mem.mem_req_o     = r_req;
  assign mem.mem_we_o      = r_we;
  assign mem.mem_addr_o32  = r_addr;
  assign mem.mem_wdata_o32 = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mcp_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp_mem_port
// Brief    : Directed and randomized self-checking bench for mcp_mem_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcp_mem_port;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic [DATA_W-1:0] pc_i32 = '0;
  logic [DATA_W-1:0] alu_out_i32 = '0;
  logic [DATA_W-1:0] wdata_i32 = '0;
  logic              instr_or_data_i = 1'b0;
  logic              instr_we_i = 1'b0;
  logic              enable_wmem_i = 1'b0;
  logic              mem_rd_i = 1'b0;
  logic              stall_o;
  logic [DATA_W-1:0] instr_o32;
  logic [DATA_W-1:0] data_o32;
  logic              bus_err_o;

  int checks   = 0;
  int failures = 0;

  // Reference state: what IR, MDR and the error flag must hold.
  logic [31:0] m_ir  = '0;
  logic [31:0] m_mdr = '0;
  logic        m_err = 1'b0;

  mcp_mem_port_if #(.DATA_W(DATA_W)) mem_bus ();

  mcp_mem_port #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .pc_i32          (pc_i32),
    .alu_out_i32     (alu_out_i32),
    .wdata_i32       (wdata_i32),
    .instr_or_data_i (instr_or_data_i),
    .instr_we_i      (instr_we_i),
    .enable_wmem_i   (enable_wmem_i),
    .mem_rd_i        (mem_rd_i),
    .stall_o         (stall_o),
    .instr_o32       (instr_o32),
    .data_o32        (data_o32),
    .bus_err_o       (bus_err_o),
    .mem             (mem_bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One controller access; expectations come from the access rules, not the FSM.
  task automatic access(input string tag, input bit iw, input bit rd, input bit wm,
                        input bit iord, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    bit          is_fetch = iw;
    bit          is_load  = !iw && rd;
    bit          is_store = !iw && !rd && wm;
    bit          tmo      = (waits >= TIMEOUT);
    int          exp_req  = tmo ? TIMEOUT : waits + 1;
    logic [31:0] exp_addr = iord ? alu : pc;
    int          req_seen = 0;
    int          stall_seen = 0;
    bit          done = 1'b0;

    instr_we_i = iw; mem_rd_i = rd; enable_wmem_i = wm;
    instr_or_data_i = iord; pc_i32 = pc; alu_out_i32 = alu; wdata_i32 = wd;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      mem_bus.mem_ack_i = (mem_bus.mem_req_o === 1'b1) && !tmo && (req_seen == waits);
      mem_bus.mem_rdata_i32 = mem_bus.mem_ack_i ? rdata : $urandom;
      #1;
      if (stall_o !== 1'b1) begin
        done = 1'b1;
      end else begin
        stall_seen++;
        if (mem_bus.mem_req_o === 1'b1) begin
          req_seen++;
          chk({tag, "_addr"}, mem_bus.mem_addr_o32, exp_addr);
          chk({tag, "_we"}, {31'b0, mem_bus.mem_we_o}, {31'b0, is_store});
          chk({tag, "_wdata"}, mem_bus.mem_wdata_o32, wd);
        end
        tick();
      end
    end
    mem_bus.mem_ack_i = 1'b0;

    if (!tmo && is_fetch) m_ir = rdata;
    if (!tmo && is_load) m_mdr = rdata;
    if (tmo || (iw && wm)) m_err = 1'b1;

    chk({tag, "_bounded"}, {31'b0, done}, 32'd1);
    chk({tag, "_stall_cycles"}, stall_seen, exp_req + 1);
    chk({tag, "_req_cycles"}, req_seen, exp_req);
    chk({tag, "_done_req"}, {31'b0, mem_bus.mem_req_o}, 32'd0);
    chk({tag, "_done_we"}, {31'b0, mem_bus.mem_we_o}, 32'd0);
    chk({tag, "_ir"}, instr_o32, m_ir);
    chk({tag, "_mdr"}, data_o32, m_mdr);
    chk({tag, "_err"}, {31'b0, bus_err_o}, {31'b0, m_err});

    // Strobes stay up through DONE; they must not start a second access.
    tick();
    instr_we_i = 1'b0; mem_rd_i = 1'b0; enable_wmem_i = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, {31'b0, stall_o}, 32'd0);
    chk({tag, "_idle_req"}, {31'b0, mem_bus.mem_req_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] snap_ir;
    logic [31:0] snap_mdr;

    mem_bus.mem_ack_i = 1'b0;
    mem_bus.mem_rdata_i32 = '0;

    // Reset state
    tick(); tick();
    chk("rst_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
    chk("rst_we", {31'b0, mem_bus.mem_we_o}, 32'd0);
    chk("rst_addr", mem_bus.mem_addr_o32, 32'd0);
    chk("rst_wdata", mem_bus.mem_wdata_o32, 32'd0);
    chk("rst_ir", instr_o32, 32'd0);
    chk("rst_mdr", data_o32, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    reset_ni = 1'b1;
    tick();

    // Directed: fetch zero-wait, load with 3 waits, store with 1 wait
    access("fetch0", 1, 0, 0, 0, 32'h40, 32'h999, 32'h0, 0, 32'h8C220004);
    access("load3", 0, 1, 0, 1, 32'h44, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    access("store1", 0, 0, 1, 1, 32'h48, 32'h200, 32'h12345678, 1, 32'hCAFEF00D);

    // Timeout: ack never comes
    access("timeout", 1, 0, 0, 0, 32'h4C, 32'h0, 32'h0, TIMEOUT + 5, 32'h0);
    access("post_tmo", 1, 0, 0, 0, 32'h50, 32'h0, 32'h0, 2, 32'h2402000A);

    // Illegal fetch+store combination
    access("illegal", 1, 0, 1, 0, 32'h54, 32'h300, 32'hFFFF0000, 0, 32'h00851020);

    // Reset two cycles into a load, with a late ack
    instr_or_data_i = 1'b1; alu_out_i32 = 32'h400; mem_rd_i = 1'b1;
    tick(); tick();
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i32 = 32'hBAADF00D;
    reset_ni = 1'b0;
    #1;
    chk("rstreq_req_async", {31'b0, mem_bus.mem_req_o}, 32'd0);
    chk("rstreq_ir", instr_o32, 32'd0);
    chk("rstreq_mdr", data_o32, 32'd0);
    chk("rstreq_err", {31'b0, bus_err_o}, 32'd0);
    tick(); tick();
    mem_rd_i = 1'b0;
    reset_ni = 1'b1;
    tick();
    chk("late_ack_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_o}, 32'd0);
    chk("late_ack_mdr", data_o32, 32'd0);
    mem_bus.mem_ack_i = 1'b0;
    m_ir = '0; m_mdr = '0; m_err = 1'b0;
    tick();

    // Spurious ack in IDLE
    access("pre_spur", 0, 1, 0, 1, 32'h0, 32'h500, 32'h0, 1, 32'h13572468);
    snap_ir = instr_o32; snap_mdr = data_o32;
    mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i32 = 32'h11112222;
    tick(); tick();
    mem_bus.mem_ack_i = 1'b0;
    chk("spur_ir", instr_o32, m_ir);
    chk("spur_mdr", data_o32, m_mdr);
    chk("spur_ir_hold", instr_o32, snap_ir);
    chk("spur_mdr_hold", data_o32, snap_mdr);
    chk("spur_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
    chk("spur_stall", {31'b0, stall_o}, 32'd0);
    chk("spur_err", {31'b0, bus_err_o}, 32'd0);

    // Randomized accesses against the reference model
    for (int n = 0; n < 24; n++) begin
      logic [2:0] strobes = 3'($urandom_range(1, 7));
      int         waits   = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 4));
      access($sformatf("rnd%0d", n), strobes[2], strobes[1], strobes[0], 1'($urandom),
             $urandom, $urandom, $urandom, waits, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
